// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), WIDTH iterations plus a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_raw_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH+1:0]   w_rem_sh;
  logic [WIDTH+1:0]   w_diff;
  logic               w_qbit;
  logic [WIDTH:0]     w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;
  logic               w_div0;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand magnitudes and sign capture at launch
  always_comb begin
    w_signed = ~op[0];
    w_a_neg  = w_signed & srcA[WIDTH-1];
    w_b_neg  = w_signed & srcB[WIDTH-1];
    w_abs_a  = w_a_neg ? (~srcA + 1'b1) : srcA;
    w_abs_b  = w_b_neg ? (~srcB + 1'b1) : srcB;
  end

  // Multiply step: add multiplicand into the upper half when the current multiplier bit is set
  always_comb begin
    w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_mag_b[0]) begin
      w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
    end
  end

  // Restoring divide step: a non-negative trial difference yields a quotient 1
  always_comb begin
    w_rem_sh  = {r_rem, r_mag_a[WIDTH-1]};
    w_diff    = w_rem_sh - {2'b00, r_mag_b};
    w_qbit    = ~w_diff[WIDTH+1];
    w_rem_nxt = w_qbit ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
  end

  always_comb begin
    w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rmd  = r_neg_rem ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
    w_div0 = (r_mag_b == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_op      <= 2'b00;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_raw_a   <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_mag_a   <= w_abs_a;
            r_mag_b   <= w_abs_b;
            r_raw_a   <= srcA;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_acc     <= '0;
            r_rem     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            if (mthi) r_hi <= srcA;
            if (mtlo) r_lo <= srcA;
          end
        end
        S_RUN: begin
          if (r_op[1]) begin
            // Dividend shifts out MSB first; quotient bits shift into the low half of the accumulator
            r_rem               <= w_rem_nxt;
            r_mag_a             <= r_mag_a << 1;
            r_acc[WIDTH-1:0]    <= {r_acc[WIDTH-2:0], w_qbit};
          end else begin
            r_acc   <= {w_add, r_acc[WIDTH-1:1]};
            r_mag_b <= r_mag_b >> 1;
          end
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_div0) begin
            // Divide by zero returns the raw dividend and an all-ones quotient
            r_hi <= r_raw_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, HI/LO moves and reset abort.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_hilo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launches at the current negedge and returns at the negedge where done is visible.
  // poke > 0 injects a start+mthi+mtlo attempt at that busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int poke);
    int cnt;
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcA  = ~a;
    srcB  = ~b;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 16) check({tag, "_hold"}, {hi, lo}, exp_hilo);
      if (cnt == poke) begin
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        op    = 2'b11;
        srcA  = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cnt), 64'd33);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    exp_hilo = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_hilo = 64'd0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    srcA  = '0;
    srcB  = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    @(negedge clk);
    check("done_width", {63'd0, done}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, -1);
    // back-to-back launch in the done cycle
    run_op("multu_b2b", 2'b01, 32'hFFFF_FFF9, 32'd3, 64'h0000_0002_FFFF_FFEB, -1);
    @(negedge clk);

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
    run_op("divu", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1);
    run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, -1);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, -1);
    run_op("div_mixed", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, -1);
    @(negedge clk);

    mthi = 1'b1;
    srcA = 32'hAAAA_5555;
    @(negedge clk);
    mthi = 1'b0;
    srcA = 32'h0;
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
    check("mthi_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    check("mthi_no_done", {63'd0, done}, 64'd0);

    mthi = 1'b1;
    mtlo = 1'b1;
    srcA = 32'h1357_9BDF;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthilo", {hi, lo}, 64'h1357_9BDF_1357_9BDF);
    exp_hilo = 64'h1357_9BDF_1357_9BDF;

    mtlo  = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    srcA  = 32'd2;
    srcB  = 32'd3;
    run_op("multu_poke", 2'b01, 32'd2, 32'd3, {32'd0, 32'd6}, 10);
    @(negedge clk);

    op    = 2'b11;
    srcA  = 32'hFFFF_0000;
    srcB  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    exp_hilo = 64'd0;
    run_op("after_abort", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
